ether_out: RTL

- RMII transmit framer. It is the egress counterpart of the ether/bitorder receive chain.
- Accepts frame bytes (destination MAC through end of payload) over a valid/ready/last byte stream.
- Emits preamble, SFD, payload, optional zero pad and CRC-32 FCS as RMII dibits on eth_txen/eth_txd, then enforces the inter-frame gap.
- Runs on eth_refclk (50 MHz), one dibit per cycle.

---
 rtl/ether_out.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ether_out.sv
// ether_out: RMII transmit framer. Takes frame bytes (destination MAC through
// end of payload) on a valid/ready/last byte stream and sends preamble, SFD,
// payload, optional zero pad and CRC-32 FCS as dibits, then holds the
// inter-frame gap.
// Optional feature macro: ETHER_OUT_PAD_EN. When it is defined, frames shorter
// than MIN_FRAME_BYTES are zero-padded before the FCS. When it is undefined,
// there is no PAD state and no byte counter.
module ether_out #(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_CYCLES      = 48
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       axiiv,
  input  logic [7:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic       eth_txen,
  output logic [1:0] eth_txd,
  output logic       busy,
  output logic       underrun
);

  localparam int PRE_CYCLES = 4 * (PREAMBLE_BYTES + 1);
  localparam int CNT_MAX0   = (PRE_CYCLES > IFG_CYCLES) ? PRE_CYCLES : IFG_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX0 > 16) ? CNT_MAX0 : 16;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] DIB_LAST = CNT_W'(3);
  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_POLY = 32'hEDB8_8320;

  if (PREAMBLE_BYTES < 1 || IFG_CYCLES < 1 || MIN_FRAME_BYTES < 1) begin : g_param_check
    $error("ether_out: PREAMBLE_BYTES, IFG_CYCLES and MIN_FRAME_BYTES must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_PAY, S_FCS, S_IFG
`ifdef ETHER_OUT_PAD_EN
    , S_PAD
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [7:0]       data_q, data_d;
  logic             last_q, last_d;
  logic             axiir_q, axiir_d;
  logic             txen_q, txen_d;
  logic [1:0]       txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
  logic [31:0]      fcs;

`ifdef ETHER_OUT_PAD_EN
  localparam int                BYTE_W    = $clog2(MIN_FRAME_BYTES + 1);
  localparam logic [BYTE_W-1:0] MIN_BYTES = BYTE_W'(MIN_FRAME_BYTES);
  logic [BYTE_W-1:0] bytes_q, bytes_d;
  logic [BYTE_W-1:0] bytes_inc;
  // Saturating count of bytes in the frame, pad bytes included.
  assign bytes_inc = (bytes_q == MIN_BYTES) ? bytes_q : bytes_q + 1'b1;
`endif

  // Reflected CRC-32 advanced over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Next-state logic: sequencing, byte capture, CRC and abort on starvation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    data_d     = data_q;
    last_d     = last_q;
    underrun_d = 1'b0;
`ifdef ETHER_OUT_PAD_EN
    bytes_d    = bytes_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (axiiv) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end
      S_PRE, S_PAY: begin
        if ((state_q == S_PRE && cnt_q == PRE_LAST) ||
            (state_q == S_PAY && cnt_q == DIB_LAST && !last_q)) begin
          // A ready cycle: take the next byte or abort the frame.
          if (axiiv) begin
            state_d = S_PAY;
            cnt_d   = '0;
            data_d  = axiid;
            last_d  = axiil;
            crc_d   = crc_byte(crc_q, axiid);
`ifdef ETHER_OUT_PAD_EN
            bytes_d = bytes_inc;
`endif
          end else begin
            state_d    = S_IFG;
            cnt_d      = '0;
            crc_d      = CRC_INIT;
            underrun_d = 1'b1;
`ifdef ETHER_OUT_PAD_EN
            bytes_d    = '0;
`endif
          end
        end else if (state_q == S_PAY && cnt_q == DIB_LAST) begin
`ifdef ETHER_OUT_PAD_EN
          if (bytes_q < MIN_BYTES) begin
            state_d = S_PAD;
            cnt_d   = '0;
            data_d  = 8'h00;
            crc_d   = crc_byte(crc_q, 8'h00);
            bytes_d = bytes_inc;
          end else begin
            state_d = S_FCS;
            cnt_d   = '0;
          end
`else
          state_d = S_FCS;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef ETHER_OUT_PAD_EN
      S_PAD: begin
        if (cnt_q == DIB_LAST) begin
          cnt_d = '0;
          if (bytes_q == MIN_BYTES) begin
            state_d = S_FCS;
          end else begin
            crc_d   = crc_byte(crc_q, 8'h00);
            bytes_d = bytes_inc;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_FCS: begin
        if (cnt_q == FCS_LAST) begin
          state_d = S_IFG;
          cnt_d   = '0;
          crc_d   = CRC_INIT;
`ifdef ETHER_OUT_PAD_EN
          bytes_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          // A source still holding valid starts the next preamble right away.
          state_d = axiiv ? S_PRE : S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    axiir_d = 1'b0;
    txen_d  = 1'b0;
    txd_d   = 2'b00;
    busy_d  = (state_d != S_IDLE);
    fcs     = ~crc_d;
    case (state_d)
      S_PRE: begin
        txen_d  = 1'b1;
        txd_d   = (cnt_d == PRE_LAST) ? 2'b11 : 2'b01;
        axiir_d = (cnt_d == PRE_LAST);
      end
      S_PAY: begin
        txen_d  = 1'b1;
        txd_d   = data_d[{cnt_d[1:0], 1'b0} +: 2];
        axiir_d = (cnt_d == DIB_LAST) && !last_d;
      end
`ifdef ETHER_OUT_PAD_EN
      S_PAD: begin
        txen_d = 1'b1;
      end
`endif
      S_FCS: begin
        txen_d = 1'b1;
        txd_d  = fcs[{cnt_d[3:0], 1'b0} +: 2];
      end
      default: ;
    endcase
  end

  // Control and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      axiir_q    <= 1'b0;
      txen_q     <= 1'b0;
      txd_q      <= 2'b00;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef ETHER_OUT_PAD_EN
      bytes_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      axiir_q    <= axiir_d;
      txen_q     <= txen_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
`ifdef ETHER_OUT_PAD_EN
      bytes_q    <= bytes_d;
`endif
    end
  end

  // Byte being serialised; only read while in PAYLOAD/PAD, so no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    last_q <= last_d;
  end

  assign axiir    = axiir_q;
  assign eth_txen = txen_q;
  assign eth_txd  = txd_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule
